pio_instr_sequencer: RTL and testbench

PIO_INSTR_SEQUENCER -- requirements
Module: pio_instr_sequencer

---
 rtl/pio_instr_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_pio_instr_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_instr_sequencer.sv
// pio_instr_sequencer
//   Executes one HPS instruction at a time against an image buffer and a
//   filter engine. An instruction is latched on the rising edge of
//   act_ins[0] while idle, decoded, executed, and then held in DONE until
//   the HPS drops act_ins[0]. act_ins[1] aborts any operation in progress.
//
//   Optional build macro: FLT_WATCHDOG_EN -- adds a cycle watchdog on the
//   filter run. When it expires, the filter is aborted and the timeout flag
//   is set. Without the macro there is no counter and the timeout flag is
//   constant 0.
//
// Ports
//   clk_clk        in   clock, rising edge
//   reset_reset_n  in   asynchronous active-low reset
//   instrucao[31:0] in  [2:0] op, [4:3] filter sel, [17:5] addr,
//                       [25:18] wdata, [31:26] reserved
//   act_ins[1:0]   in   [0] issue (level), [1] abort
//   wait_s[1:0]    out  [0] busy, [1] done
//   data_out[31:0] out  [7:0] rdata, [8] timeout, [9] illegal op,
//                       [31:16] completed-instruction count
//   mem_addr/mem_wdata/mem_we/mem_re out, mem_rdata in : image buffer
//   flt_start/flt_sel/flt_abort out, flt_done in       : filter engine
module pio_instr_sequencer #(
  parameter int ADDR_W      = 13,
  parameter int RD_LAT      = 2,       // must be >= 1
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [31:0]       instrucao,
  input  logic [1:0]        act_ins,
  output logic [1:0]        wait_s,
  output logic [31:0]       data_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              flt_start,
  output logic [1:0]        flt_sel,
  output logic              flt_abort,
  input  logic              flt_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_MEM_WR, S_MEM_RD, S_RD_WAIT, S_FLT_RUN, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP    = 3'b000,
    OP_WRITE  = 3'b001,
    OP_READ   = 3'b010,
    OP_FILTER = 3'b011,
    OP_STATUS = 3'b100
  } op_e;

  localparam int RC_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [RC_W-1:0] RD_LAST = RC_W'(RD_LAT - 1);

  state_e              state_q, state_d;
  logic [25:0]         instr_q, instr_d;
  logic                issue_q;
  logic [RC_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                illegal_q, illegal_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic                flt_start_q, flt_start_d;
  logic [1:0]          flt_sel_q, flt_sel_d;
  logic                flt_abort_q, flt_abort_d;
  logic                timeout_flag;

  logic issue_edge, abort;
  logic unused_rsvd;

  assign issue_edge  = act_ins[0] & ~issue_q;
  assign abort       = act_ins[1];
  assign unused_rsvd = ^instrucao[31:26];

`ifdef FLT_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;

  assign timeout_flag = timeout_q;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;

  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    rd_cnt_d    = rd_cnt_q;
    rdata_d     = rdata_q;
    illegal_d   = illegal_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    flt_sel_d   = flt_sel_q;
    flt_abort_d = 1'b0;
`ifdef FLT_WATCHDOG_EN
    wd_cnt_d    = wd_cnt_q;
    timeout_d   = timeout_q;
`endif

    // Abort wins over everything, including an issue edge in IDLE and any
    // capture/decision the current state would otherwise make.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      if (state_q == S_FLT_RUN) flt_abort_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (issue_edge && !abort) begin
            instr_d   = instrucao[25:0];
            illegal_d = 1'b0;
`ifdef FLT_WATCHDOG_EN
            timeout_d = 1'b0;
`endif
            state_d   = S_DECODE;
          end
        end
        S_DECODE: begin
          case (op_e'(instr_q[2:0]))
            OP_NOP, OP_STATUS: state_d = S_DONE;
            OP_WRITE: begin
              mem_addr_d  = ADDR_W'(instr_q[17:5]);
              mem_wdata_d = instr_q[25:18];
              state_d     = S_MEM_WR;
            end
            OP_READ: begin
              mem_addr_d = ADDR_W'(instr_q[17:5]);
              state_d    = S_MEM_RD;
            end
            OP_FILTER: begin
              flt_sel_d = instr_q[4:3];
`ifdef FLT_WATCHDOG_EN
              wd_cnt_d  = '0;
`endif
              state_d   = S_FLT_RUN;
            end
            default: begin
              illegal_d = 1'b1;
              state_d   = S_DONE;
            end
          endcase
        end
        S_MEM_WR: state_d = S_DONE;
        S_MEM_RD: begin
          rd_cnt_d = '0;
          state_d  = S_RD_WAIT;
        end
        S_RD_WAIT: begin
          // Data is valid in the RD_LAT-th cycle after the mem_re cycle.
          if (rd_cnt_q == RD_LAST) begin
            rdata_d = mem_rdata;
            state_d = S_DONE;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
        S_FLT_RUN: begin
          if (flt_done) begin
            state_d = S_DONE;
          end
`ifdef FLT_WATCHDOG_EN
          // FLT_RUN lasts at most TIMEOUT_CYC cycles.
          else if (wd_cnt_q == WD_LAST) begin
            flt_abort_d = 1'b1;
            timeout_d   = 1'b1;
            state_d     = S_DONE;
          end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
`endif
        end
        S_DONE: begin
          if (!act_ins[0]) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d == S_DONE && state_q != S_DONE) cnt_d = cnt_q + 16'd1;

    mem_we_d    = (state_d == S_MEM_WR);
    mem_re_d    = (state_d == S_MEM_RD);
    flt_start_d = (state_d == S_FLT_RUN) && (state_q != S_FLT_RUN);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      issue_q     <= 1'b0;
      rd_cnt_q    <= '0;
      rdata_q     <= '0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      flt_start_q <= 1'b0;
      flt_sel_q   <= '0;
      flt_abort_q <= 1'b0;
`ifdef FLT_WATCHDOG_EN
      wd_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      issue_q     <= act_ins[0];
      rd_cnt_q    <= rd_cnt_d;
      rdata_q     <= rdata_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      flt_start_q <= flt_start_d;
      flt_sel_q   <= flt_sel_d;
      flt_abort_q <= flt_abort_d;
`ifdef FLT_WATCHDOG_EN
      wd_cnt_q    <= wd_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign wait_s[0] = (state_q == S_DECODE) || (state_q == S_MEM_WR) ||
                     (state_q == S_MEM_RD) || (state_q == S_RD_WAIT) ||
                     (state_q == S_FLT_RUN);
  assign wait_s[1] = (state_q == S_DONE);

  assign data_out  = {cnt_q, 6'b0, illegal_q, timeout_flag, rdata_q};
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign flt_start = flt_start_q;
  assign flt_sel   = flt_sel_q;
  assign flt_abort = flt_abort_q;

endmodule

// File: tb/tb_pio_instr_sequencer.sv
// Directed testbench for pio_instr_sequencer. Inputs change and outputs are
// sampled on the falling clock edge. A small image-buffer model with a
// two-cycle read latency and a hand-driven flt_done stand in for the
// external blocks. Build with FLT_WATCHDOG_EN to exercise the watchdog.
module tb_pio_instr_sequencer;

  logic        clk;
  logic        rst_n;
  logic [31:0] instrucao;
  logic [1:0]  act_ins;
  logic [1:0]  wait_s;
  logic [31:0] data_out;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic        flt_start;
  logic [1:0]  flt_sel;
  logic        flt_abort;
  logic        flt_done;

  int unsigned n_checks;
  int unsigned n_err;

  pio_instr_sequencer #(
    .ADDR_W(13),
    .RD_LAT(2),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .instrucao(instrucao),
    .act_ins(act_ins),
    .wait_s(wait_s),
    .data_out(data_out),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .mem_re(mem_re),
    .mem_rdata(mem_rdata),
    .flt_start(flt_start),
    .flt_sel(flt_sel),
    .flt_abort(flt_abort),
    .flt_done(flt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Image buffer model: data appears exactly two cycles after the mem_re cycle.
  logic [7:0] mem [0:255];
  logic [7:0] rd1, rd2;
  logic       v1, v2;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  end
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    rd1 <= mem[mem_addr[7:0]];
    v1  <= mem_re;
    rd2 <= rd1;
    v2  <= v1;
  end
  assign mem_rdata = v2 ? rd2 : 8'h00;

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [1:0] sel,
                                     input logic [12:0] addr, input logic [7:0] wd);
    return {6'b0, wd, addr, sel, op};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    n_checks  = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    instrucao = '0;
    act_ins   = 2'b00;
    flt_done  = 1'b0;
    v1 = 1'b0; v2 = 1'b0; rd1 = '0; rd2 = '0;
    tick(); tick();
    chk("rst_wait", 32'(wait_s), 32'h0);
    chk("rst_data", data_out, 32'h0);
    chk("rst_mem", 32'({mem_addr, mem_wdata, mem_we, mem_re}), 32'h0);
    chk("rst_flt", 32'({flt_start, flt_sel, flt_abort}), 32'h0);
    rst_n = 1'b1;
    tick();

    // WRITE 0x3C to 0x0A5
    instrucao = mk(3'b001, 2'd0, 13'h0A5, 8'h3C);
    act_ins   = 2'b01;
    tick();
    chk("wr_decode_busy", 32'(wait_s), 32'h1);
    chk("wr_decode_we", 32'(mem_we), 32'h0);
    tick();
    chk("wr_we", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, 13'h0A5, 8'h3C}));
    chk("wr_busy", 32'(wait_s), 32'h1);
    tick();
    chk("wr_we_off", 32'(mem_we), 32'h0);
    chk("wr_done", 32'(wait_s), 32'h2);
    chk("wr_count", data_out, 32'h0001_0000);
    tick();
    chk("wr_done_hold", 32'(wait_s), 32'h2);
    act_ins = 2'b00;
    tick();
    chk("wr_idle", 32'(wait_s), 32'h0);

    // READ from 0x0A5
    instrucao = mk(3'b010, 2'd0, 13'h0A5, 8'h00);
    act_ins   = 2'b01;
    tick();
    chk("rd_decode_busy", 32'(wait_s), 32'h1);
    tick();
    chk("rd_re", 32'({mem_re, mem_addr}), 32'({1'b1, 13'h0A5}));
    tick();
    chk("rd_re_off", 32'(mem_re), 32'h0);
    chk("rd_wait_busy", 32'(wait_s), 32'h1);
    tick();
    chk("rd_wait2_busy", 32'(wait_s), 32'h1);
    tick();
    chk("rd_done", 32'(wait_s), 32'h2);
    chk("rd_data", data_out, 32'h0002_003C);
    act_ins = 2'b00;
    tick();
    chk("rd_idle", 32'(wait_s), 32'h0);
    chk("rd_data_kept", data_out, 32'h0002_003C);

    // FILTER sel=2, completed by flt_done; DONE exits after one cycle
    instrucao = mk(3'b011, 2'd2, 13'h000, 8'h00);
    act_ins   = 2'b01;
    tick();
    chk("flt_decode_start", 32'(flt_start), 32'h0);
    tick();
    chk("flt_start", 32'({flt_start, flt_sel}), 32'({1'b1, 2'd2}));
    chk("flt_busy", 32'(wait_s), 32'h1);
    act_ins = 2'b00;
    tick();
    chk("flt_start_pulse", 32'({flt_start, flt_sel}), 32'({1'b0, 2'd2}));
    chk("flt_busy2", 32'(wait_s), 32'h1);
    flt_done = 1'b1;
    tick();
    flt_done = 1'b0;
    chk("flt_done", 32'(wait_s), 32'h2);
    chk("flt_count", data_out, 32'h0003_003C);
    tick();
    chk("flt_idle", 32'(wait_s), 32'h0);

    // flt_done outside FLT_RUN is ignored
    flt_done = 1'b1;
    tick();
    flt_done = 1'b0;
    tick();
    chk("flt_done_idle", 32'(wait_s), 32'h0);
    chk("flt_done_idle_cnt", data_out, 32'h0003_003C);

    // Abort during FLT_RUN
    instrucao = mk(3'b011, 2'd1, 13'h000, 8'h00);
    act_ins   = 2'b01;
    tick(); tick();
    chk("ab_start", 32'({flt_start, flt_sel}), 32'({1'b1, 2'd1}));
    act_ins = 2'b11;
    tick();
    chk("ab_flt_abort", 32'(flt_abort), 32'h1);
    chk("ab_wait", 32'(wait_s), 32'h0);
    chk("ab_count", data_out, 32'h0003_003C);
    act_ins = 2'b00;
    tick();
    chk("ab_flt_abort_pulse", 32'(flt_abort), 32'h0);

    // Abort together with an issue edge: stays idle
    instrucao = mk(3'b001, 2'd0, 13'h010, 8'h55);
    act_ins   = 2'b11;
    tick();
    chk("ab_issue_idle", 32'(wait_s), 32'h0);
    act_ins = 2'b00;
    tick();
    chk("ab_issue_idle2", 32'({wait_s, mem_we}), 32'h0);
    chk("ab_issue_cnt", data_out, 32'h0003_003C);

    // Illegal op, then a NOP clears the flag at DECODE
    instrucao = mk(3'b111, 2'd0, 13'h000, 8'h00);
    act_ins   = 2'b01;
    tick(); tick();
    chk("ill_done", 32'(wait_s), 32'h2);
    chk("ill_flag", data_out, 32'h0004_023C);
    act_ins = 2'b00;
    tick();
    instrucao = mk(3'b000, 2'd0, 13'h000, 8'h00);
    act_ins   = 2'b01;
    tick();
    chk("nop_decode_clr", data_out, 32'h0004_003C);
    tick();
    chk("nop_done", data_out, 32'h0005_003C);
    act_ins = 2'b00;
    tick();

    // Count wrap: preload 0xFFFF, one NOP
    force dut.cnt_q = 16'hFFFF;
    tick();
    release dut.cnt_q;
    tick();
    chk("wrap_preload", 32'(data_out[31:16]), 32'hFFFF);
    act_ins = 2'b01;
    tick(); tick();
    chk("wrap_done", 32'(wait_s), 32'h2);
    chk("wrap_count", data_out, 32'h0000_003C);
    act_ins = 2'b00;
    tick();

    // Filter run with no flt_done
    instrucao = mk(3'b011, 2'd3, 13'h000, 8'h00);
    act_ins   = 2'b01;
    tick(); tick();
    chk("wd_start", 32'({flt_start, flt_sel}), 32'({1'b1, 2'd3}));
    act_ins = 2'b00;
`ifdef FLT_WATCHDOG_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("wd_no_abort_yet", 32'({flt_abort, wait_s}), 32'h1);
    end
    tick();
    chk("wd_abort", 32'(flt_abort), 32'h1);
    chk("wd_done", 32'(wait_s), 32'h2);
    chk("wd_timeout_flag", data_out, 32'h0001_013C);
    tick();
    chk("wd_abort_pulse", 32'(flt_abort), 32'h0);
    chk("wd_idle", 32'(wait_s), 32'h0);
`else
    for (int i = 0; i < 20; i++) begin
      if (i == 7) act_ins = 2'b01;   // issue edge while busy is ignored
      tick();
    end
    chk("nowd_busy", 32'({flt_start, flt_abort, wait_s}), 32'h1);
    chk("nowd_no_timeout", data_out, 32'h0000_003C);
    flt_done = 1'b1;
    tick();
    flt_done = 1'b0;
    chk("nowd_done", 32'(wait_s), 32'h2);
    chk("nowd_count", data_out, 32'h0001_003C);
    tick();
    chk("nowd_done_hold", 32'(wait_s), 32'h2);
    act_ins = 2'b00;
    tick();
    chk("nowd_idle", 32'(wait_s), 32'h0);
`endif

    // Reset during a write: nothing left pending afterwards
    instrucao = mk(3'b001, 2'd0, 13'h01F, 8'h99);
    act_ins   = 2'b01;
    tick(); tick();
    chk("rstmid_we", 32'(mem_we), 32'h1);
    rst_n   = 1'b0;
    act_ins = 2'b00;
    #1;
    chk("rstmid_clear", 32'({mem_we, mem_re, wait_s, flt_start, flt_abort}), 32'h0);
    chk("rstmid_data", data_out, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rstmid_after", 32'({mem_we, mem_re, wait_s, flt_start, flt_abort}), 32'h0);
    tick();
    chk("rstmid_after2", 32'({mem_we, mem_re, wait_s, flt_start, flt_abort}), 32'h0);
    chk("rstmid_mem_untouched", 32'(mem[8'h1F]), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
